bp_me_router_inject_arb: RTL and testbench

- Round-robin scheduler that shares the tile router's single local (P) injection link among num_src_p on-tile coherence sources (LCE req, LCE resp, CCE cmd, ...).
- Grant is locked for the full multi-beat packet, so beats from different sources never interleave on the mesh link.
- Output passes through a one-entry ready-and register.
- Sits between the tile's LCE/CCE message encoders and the P input of the mesh router.

---
 rtl/bp_me_network_pkg.sv | 26 ++
 rtl/bp_me_rr_pick.sv | 36 +++
 rtl/bp_me_router_inject_arb.sv | 150 +++++++++++++++
 tb/tb_bp_me_router_inject_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_network_pkg.sv
// Shared types for the tile network-side schedulers: arbitration states,
// the per-source beat struct macro and a width helper.
`ifndef BP_ME_NETWORK_PKG_SV
`define BP_ME_NETWORK_PKG_SV

`define BP_ME_DECLARE_BEAT_S(data_width_mp, len_width_mp) \
    typedef struct packed {                                 \
        logic [data_width_mp-1:0] data;                     \
        logic [len_width_mp-1:0]  len;                      \
    } bp_me_beat_s

package bp_me_network_pkg;

    typedef enum logic {
        e_arb_idle,
        e_arb_locked
    } arb_state_e;

    // Index width that never collapses to zero bits for tiny vectors.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/bp_me_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i,
// wrapping at num_src_p with an explicit compare so non-power-of-2 counts work.
import bp_me_network_pkg::*;

module bp_me_rr_pick #(
    parameter  int num_src_p   = 4,
    localparam int id_width_lp = safe_clog2(num_src_p)
) (
    input  logic [num_src_p-1:0]   eligible_i,
    input  logic [id_width_lp-1:0] rr_ptr_i,
    output logic [num_src_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic                   found_o
);

    int cand;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found_o    = 1'b0;
        cand       = 0;
        for (int k = 0; k < num_src_p; k++) begin
            cand = int'(rr_ptr_i) + k;
            if (cand >= num_src_p) begin
                cand = cand - num_src_p;
            end
            if (!found_o && eligible_i[cand]) begin
                found_o       = 1'b1;
                grant_o[cand] = 1'b1;
                grant_id_o    = id_width_lp'(cand);
            end
        end
    end

endmodule

// File: rtl/bp_me_router_inject_arb.sv
// Shares the router P injection link among on-tile sources; the grant is held
// for a whole packet and beats leave through a one-entry ready-and register.
import bp_me_network_pkg::*;

module bp_me_router_inject_arb #(
    parameter  int num_src_p       = 4,
    parameter  int width_p         = 64,
    parameter  int len_width_p     = 4,
    localparam int src_id_width_lp = safe_clog2(num_src_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_src_p-1:0]             en_i,
    input  logic [num_src_p*width_p-1:0]     data_i,
    input  logic [num_src_p*len_width_p-1:0] len_i,
    input  logic [num_src_p-1:0]             v_i,
    output logic [num_src_p-1:0]             ready_o,
    output logic [width_p-1:0]               data_o,
    output logic [src_id_width_lp-1:0]       src_id_o,
    output logic                             last_o,
    output logic                             v_o,
    input  logic                             ready_i,
    output logic                             locked_o
);

    `BP_ME_DECLARE_BEAT_S(width_p, len_width_p);

    localparam logic [src_id_width_lp-1:0] last_id_lp = src_id_width_lp'(num_src_p - 1);

    bp_me_beat_s beats [num_src_p];

    for (genvar i = 0; i < num_src_p; i++) begin : g_unpack
        assign beats[i].data = data_i[i*width_p +: width_p];
        assign beats[i].len  = len_i[i*len_width_p +: len_width_p];
    end

    arb_state_e                 state_q, state_d;
    logic [src_id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [src_id_width_lp-1:0] lock_id_q, lock_id_d;
    logic [len_width_p-1:0]     beat_cnt_q, beat_cnt_d;
    logic [width_p-1:0]         data_q, data_d;
    logic [src_id_width_lp-1:0] src_id_q, src_id_d;
    logic                       last_q, last_d;
    logic                       v_q, v_d;

    logic [num_src_p-1:0]       pick_grant;
    logic [src_id_width_lp-1:0] pick_id;
    logic                       pick_found;
    logic [num_src_p-1:0]       grant;
    logic [src_id_width_lp-1:0] sel_id;
    logic                       out_free;
    logic                       accept;
    bp_me_beat_s                sel_beat;

    function automatic logic [src_id_width_lp-1:0] next_id(input logic [src_id_width_lp-1:0] id);
        return (id == last_id_lp) ? '0 : id + src_id_width_lp'(1);
    endfunction

    bp_me_rr_pick #(
        .num_src_p(num_src_p)
    ) u_pick (
        .eligible_i(v_i & en_i),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (pick_grant),
        .grant_id_o(pick_id),
        .found_o   (pick_found)
    );

    // While locked only the packet owner may be served, even if it stalls.
    always_comb begin
        grant  = '0;
        sel_id = '0;
        if (state_q == e_arb_locked) begin
            grant[lock_id_q] = 1'b1;
            sel_id           = lock_id_q;
        end else if (pick_found) begin
            grant  = pick_grant;
            sel_id = pick_id;
        end
        out_free = !v_q || ready_i;
        ready_o  = grant & {num_src_p{out_free}};
        accept   = |(ready_o & v_i);
        sel_beat = beats[sel_id];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        src_id_d   = src_id_q;
        last_d     = last_q;
        v_d        = v_q;
        if (accept) begin
            data_d   = sel_beat.data;
            src_id_d = sel_id;
            v_d      = 1'b1;
            if (state_q == e_arb_idle) begin
                if (sel_beat.len == '0) begin
                    last_d   = 1'b1;
                    rr_ptr_d = next_id(sel_id);
                end else begin
                    state_d    = e_arb_locked;
                    lock_id_d  = sel_id;
                    beat_cnt_d = sel_beat.len;
                    last_d     = 1'b0;
                end
            end else begin
                beat_cnt_d = beat_cnt_q - len_width_p'(1);
                last_d     = (beat_cnt_q == len_width_p'(1));
                if (beat_cnt_q == len_width_p'(1)) begin
                    state_d  = e_arb_idle;
                    rr_ptr_d = next_id(lock_id_q);
                end
            end
        end else if (ready_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_arb_idle;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
            data_q     <= '0;
            src_id_q   <= '0;
            last_q     <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            src_id_q   <= src_id_d;
            last_q     <= last_d;
            v_q        <= v_d;
        end
    end

    assign data_o   = data_q;
    assign src_id_o = src_id_q;
    assign last_o   = last_q;
    assign v_o      = v_q;
    assign locked_o = (state_q == e_arb_locked);

endmodule

// File: tb/tb_bp_me_router_inject_arb.sv
// Directed bench for the injection arbiter: fairness, packet locking, bubbles,
// backpressure, enable masking and asynchronous reset mid-packet.
module tb_bp_me_router_inject_arb;

    localparam int N = 4;
    localparam int W = 64;
    localparam int L = 4;

    logic           clk_i;
    logic           reset_i;
    logic [N-1:0]   en_i;
    logic [N*W-1:0] data_i;
    logic [N*L-1:0] len_i;
    logic [N-1:0]   v_i;
    logic [N-1:0]   ready_o;
    logic [W-1:0]   data_o;
    logic [1:0]     src_id_o;
    logic           last_o;
    logic           v_o;
    logic           ready_i;
    logic           locked_o;

    int checkCount;
    int errorCount;

    bp_me_router_inject_arb #(
        .num_src_p  (N),
        .width_p    (W),
        .len_width_p(L)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .data_i  (data_i),
        .len_i   (len_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .src_id_o(src_id_o),
        .last_o  (last_o),
        .v_o     (v_o),
        .ready_i (ready_i),
        .locked_o(locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [L-1:0] len,
                                 input logic [W-1:0] data);
        v_i[i]          = v;
        len_i[i*L +: L] = len;
        data_i[i*W +: W] = data;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkBeat(input string tag, input int src, input logic last,
                             input logic [W-1:0] data);
        checkOutput({tag, ".v"}, 64'(v_o), 64'd1);
        checkOutput({tag, ".src"}, 64'(src_id_o), 64'(src));
        checkOutput({tag, ".last"}, 64'(last_o), 64'(last));
        checkOutput({tag, ".data"}, data_o, data);
    endtask

    task automatic clearSources();
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, '0, '0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        en_i    = 4'hF;
        v_i     = '0;
        len_i   = '0;
        data_i  = '0;
        ready_i = 1'b1;
        reset_i = 1'b1;
        #12;
        checkOutput("rst.v", 64'(v_o), 64'd0);
        checkOutput("rst.last", 64'(last_o), 64'd0);
        checkOutput("rst.src", 64'(src_id_o), 64'd0);
        checkOutput("rst.data", data_o, 64'd0);
        checkOutput("rst.locked", 64'(locked_o), 64'd0);
        checkOutput("rst.ready", 64'(ready_o), 64'd0);
        #2 reset_i = 1'b0;
        tick();

        // Fairness: every source single-beat, strict rotation starting at 0
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 4'd0, 64'hA0 + 64'(i));
        #1;
        checkOutput("fair.ready0", 64'(ready_o), 64'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkBeat($sformatf("fair%0d", k), k % 4, 1'b1, 64'hA0 + 64'(k % 4));
        end
        clearSources();
        tick();
        checkOutput("fair.drain", 64'(v_o), 64'd0);

        // Lock: src1 four-beat packet keeps src2 waiting
        applyStimulus(1, 1'b1, 4'd3, 64'h11);
        applyStimulus(2, 1'b1, 4'd0, 64'h22);
        tick();
        checkBeat("lock.h", 1, 1'b0, 64'h11);
        checkOutput("lock.locked0", 64'(locked_o), 64'd1);
        checkOutput("lock.ready", 64'(ready_o), 64'b0010);
        tick();
        checkBeat("lock.b1", 1, 1'b0, 64'h11);
        checkOutput("lock.locked1", 64'(locked_o), 64'd1);
        tick();
        checkBeat("lock.b2", 1, 1'b0, 64'h11);
        checkOutput("lock.locked2", 64'(locked_o), 64'd1);
        tick();
        checkBeat("lock.b3", 1, 1'b1, 64'h11);
        checkOutput("lock.locked3", 64'(locked_o), 64'd0);
        applyStimulus(1, 1'b0, 4'd0, 64'h0);
        tick();
        checkBeat("lock.next", 2, 1'b1, 64'h22);
        clearSources();
        tick();
        checkOutput("lock.drain", 64'(v_o), 64'd0);

        // Bubble: src0 stalls mid-packet, src3 must wait
        applyStimulus(0, 1'b1, 4'd2, 64'h30);
        tick();
        checkBeat("bub.h", 0, 1'b0, 64'h30);
        applyStimulus(0, 1'b0, 4'd0, 64'h30);
        applyStimulus(3, 1'b1, 4'd0, 64'h33);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput($sformatf("bub.gap%0d.v", k), 64'(v_o), 64'd0);
            checkOutput($sformatf("bub.gap%0d.locked", k), 64'(locked_o), 64'd1);
            checkOutput($sformatf("bub.gap%0d.ready", k), 64'(ready_o), 64'b0001);
        end
        applyStimulus(0, 1'b1, 4'd0, 64'h31);
        tick();
        checkBeat("bub.b1", 0, 1'b0, 64'h31);
        tick();
        checkBeat("bub.b2", 0, 1'b1, 64'h31);
        applyStimulus(0, 1'b0, 4'd0, 64'h0);
        tick();
        checkBeat("bub.src3", 3, 1'b1, 64'h33);
        clearSources();
        tick();
        checkOutput("bub.drain", 64'(v_o), 64'd0);

        // Backpressure: src2 packet held for five stalled cycles
        applyStimulus(2, 1'b1, 4'd2, 64'h40);
        tick();
        checkBeat("bp.h", 2, 1'b0, 64'h40);
        ready_i = 1'b0;
        applyStimulus(2, 1'b1, 4'd0, 64'h41);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("bp.hold%0d.data", k), data_o, 64'h40);
            checkOutput($sformatf("bp.hold%0d.ready", k), 64'(ready_o), 64'd0);
            checkOutput($sformatf("bp.hold%0d.locked", k), 64'(locked_o), 64'd1);
        end
        ready_i = 1'b1;
        tick();
        checkBeat("bp.b1", 2, 1'b0, 64'h41);
        applyStimulus(2, 1'b1, 4'd0, 64'h42);
        tick();
        checkBeat("bp.b2", 2, 1'b1, 64'h42);
        clearSources();
        tick();
        checkOutput("bp.drain", 64'(v_o), 64'd0);

        // Config: only sources 1 and 3 enabled, rotation resumes at 3
        en_i = 4'b1010;
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 4'd0, 64'hA0 + 64'(i));
        for (int k = 0; k < 4; k++) begin
            tick();
            checkBeat($sformatf("cfg%0d", k), (k % 2 == 0) ? 3 : 1, 1'b1,
                      (k % 2 == 0) ? 64'hA3 : 64'hA1);
        end
        clearSources();
        applyStimulus(1, 1'b1, 4'd2, 64'h51);
        tick();
        checkBeat("cfg.h", 1, 1'b0, 64'h51);
        en_i = 4'b1000;
        applyStimulus(3, 1'b1, 4'd0, 64'h53);
        tick();
        checkBeat("cfg.b1", 1, 1'b0, 64'h51);
        tick();
        checkBeat("cfg.b2", 1, 1'b1, 64'h51);
        en_i = 4'hF;
        clearSources();
        tick();
        checkOutput("cfg.drain", 64'(v_o), 64'd0);

        // Reset mid-packet, then first grant goes back to source 0
        applyStimulus(0, 1'b1, 4'd3, 64'h60);
        tick();
        checkBeat("rm.h", 0, 1'b0, 64'h60);
        tick();
        checkBeat("rm.b1", 0, 1'b0, 64'h60);
        #2 reset_i = 1'b1;
        #1;
        checkOutput("rm.v", 64'(v_o), 64'd0);
        checkOutput("rm.locked", 64'(locked_o), 64'd0);
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 4'd0, 64'h70 + 64'(i));
        #1 reset_i = 1'b0;
        tick();
        checkBeat("rm.first", 0, 1'b1, 64'h70);
        tick();
        checkBeat("rm.second", 1, 1'b1, 64'h71);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
